// File: rtl/insn_prefetcher_pkg.sv
// ============================================================================
// Module   : insn_prefetcher_pkg
// Brief    : Shared instruction-fetch widths, default queue depth, helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package insn_prefetcher_pkg;

    localparam int c_LEN_INSN      = 32;
    localparam int c_MEM_INSN_ADDR = 8;
    localparam int c_DEPTH         = 4;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/insn_prefetcher_if.sv
// ============================================================================
// Module   : insn_prefetcher_if
// Brief    : Memory, control and downstream bundle of the prefetcher.
//            Perf ports present only with INSN_PREFETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface insn_prefetcher_if
    import insn_prefetcher_pkg::*;
#(
    parameter int LEN_INSN      = c_LEN_INSN,
    parameter int MEM_INSN_ADDR = c_MEM_INSN_ADDR
);

    logic                     en_i;
    logic                     redirect_i;
    logic [MEM_INSN_ADDR-1:0] redirect_addr_i;
    logic                     stall_i;
    logic                     valid_o;
    logic [LEN_INSN-1:0]      insn_o;
    logic [MEM_INSN_ADDR-1:0] pc_o;
    logic [MEM_INSN_ADDR-1:0] mem_addr;
    logic                     mem_rd;
    logic [LEN_INSN-1:0]      mem_q;
`ifdef INSN_PREFETCH_PERF_EN
    logic [31:0]              perf_stall_cnt_o;
    logic [15:0]              perf_flush_cnt_o;

    modport master (
        input  en_i, redirect_i, redirect_addr_i, stall_i, mem_q,
        output valid_o, insn_o, pc_o, mem_addr, mem_rd,
        output perf_stall_cnt_o, perf_flush_cnt_o
    );

    modport slave (
        output en_i, redirect_i, redirect_addr_i, stall_i, mem_q,
        input  valid_o, insn_o, pc_o, mem_addr, mem_rd,
        input  perf_stall_cnt_o, perf_flush_cnt_o
    );
`else
    modport master (
        input  en_i, redirect_i, redirect_addr_i, stall_i, mem_q,
        output valid_o, insn_o, pc_o, mem_addr, mem_rd
    );

    modport slave (
        output en_i, redirect_i, redirect_addr_i, stall_i, mem_q,
        input  valid_o, insn_o, pc_o, mem_addr, mem_rd
    );
`endif

endinterface

`default_nettype wire

// File: rtl/insn_prefetcher_fifo.sv
// ============================================================================
// Module   : insn_fifo
// Brief    : DEPTH-deep queue with flush (over push), combinational head read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module insn_fifo
    import insn_prefetcher_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
)(
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          flush,
    input  wire logic                          push,
    input  wire logic                          pop,
    input  wire logic [WIDTH-1:0]              wdata,
    output logic      [count_width(DEPTH)-1:0] count,
    output logic      [WIDTH-1:0]              head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    // Storage is cleared on reset so the head never shows X before first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/insn_prefetcher.sv
// ============================================================================
// Module   : insn_prefetcher
// Brief    : Sequential fetch from 1-cycle sync memory into a prefetch queue,
//            with redirect/flush and PC tags. Option: INSN_PREFETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module insn_prefetcher
    import insn_prefetcher_pkg::*;
#(
    parameter int                       LEN_INSN      = c_LEN_INSN,
    parameter int                       MEM_INSN_ADDR = c_MEM_INSN_ADDR,
    parameter int                       DEPTH         = c_DEPTH,
    parameter logic [MEM_INSN_ADDR-1:0] RESET_ADDR    = '0
)(
    input  wire logic          clk,
    input  wire logic          rst,
    insn_prefetcher_if.master  bus
);

    localparam int CW = count_width(DEPTH);
    localparam int EW = LEN_INSN + MEM_INSN_ADDR;

    logic [CW-1:0]            w_count;
    logic [EW-1:0]            w_head;
    logic [CW:0]              w_level;
    logic [MEM_INSN_ADDR-1:0] w_addr;
    logic                     w_valid;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_issue;

    logic                     r_inflight;
    logic [MEM_INSN_ADDR-1:0] r_pc;
    logic [MEM_INSN_ADDR-1:0] r_issued_addr;

    // w_level is the occupancy after this edge once the in-flight read lands;
    // issuing only below DEPTH keeps the next return from overflowing.
    always_comb begin
        w_valid = (w_count != '0) && !bus.redirect_i;
        w_pop   = w_valid && !bus.stall_i;
        w_push  = r_inflight && !bus.redirect_i;
        w_addr  = bus.redirect_i ? bus.redirect_addr_i : r_pc;
        w_level = (CW+1)'(w_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
        w_issue = bus.en_i && (bus.redirect_i || (w_level < (CW+1)'(DEPTH)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_ADDR;
            r_inflight    <= 1'b0;
            r_issued_addr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= w_addr + MEM_INSN_ADDR'(1);
                r_issued_addr <= w_addr;
            end else if (bus.redirect_i) begin
                r_pc <= bus.redirect_addr_i;
            end
        end
    end

    insn_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_i),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({bus.mem_q, r_issued_addr}),
        .count (w_count),
        .head  (w_head)
    );

    assign bus.mem_addr = w_addr;
    assign bus.mem_rd   = w_issue;
    assign bus.valid_o  = w_valid;
    assign bus.insn_o   = w_head[EW-1 -: LEN_INSN];
    assign bus.pc_o     = w_head[MEM_INSN_ADDR-1:0];

`ifdef INSN_PREFETCH_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [15:0] r_perf_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_valid && bus.stall_i && (r_perf_stall_cnt != '1)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (bus.redirect_i && (r_perf_flush_cnt != '1)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cnt_o = r_perf_stall_cnt;
    assign bus.perf_flush_cnt_o = r_perf_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_insn_prefetcher.sv
// ============================================================================
// Module   : tb_insn_prefetcher
// Brief    : Directed plus random stimulus against a stream-order model of the
//            prefetcher; perf counters modelled when INSN_PREFETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_insn_prefetcher;

    localparam int LEN = 32;
    localparam int AW  = 8;
    localparam int DEP = 4;
    localparam logic [AW-1:0] RST_PC = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    insn_prefetcher_if #(.LEN_INSN(LEN), .MEM_INSN_ADDR(AW)) bus ();

    insn_prefetcher #(
        .LEN_INSN      (LEN),
        .MEM_INSN_ADDR (AW),
        .DEPTH         (DEP),
        .RESET_ADDR    (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [LEN-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_q <= mem[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: the delivered stream is consecutive PCs from the last
    // redirect target (or reset address), each carrying mem[pc].
    logic [AW-1:0]  exp_pc     = RST_PC;
    int             since_rst  = 0;
    bit             en_h1      = 0;
    bit             en_h2      = 0;
    bit             prev_redir = 0;
    bit             hold_v     = 0;
    logic [AW-1:0]  hold_pc    = '0;
    logic [LEN-1:0] hold_insn  = '0;
    longint         m_stall    = 0;
    longint         m_flush    = 0;

    task automatic check(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        check({tag, "_insn"},  bus.insn_o,       32'd0);
        check({tag, "_pc"},    32'(bus.pc_o),    32'd0);
`ifdef INSN_PREFETCH_PERF_EN
        check({tag, "_pstall"}, bus.perf_stall_cnt_o,      32'd0);
        check({tag, "_pflush"}, 32'(bus.perf_flush_cnt_o), 32'd0);
`endif
    endtask

    task automatic step(input bit en, input bit redir, input logic [AW-1:0] raddr,
                        input bit stall, input bit pulse_rst = 1'b0);
        bit xfer;
        @(negedge clk);
        bus.en_i            = en;
        bus.redirect_i      = redir;
        bus.redirect_addr_i = raddr;
        bus.stall_i         = stall;
        #1;
        if (since_rst < 2) check("startup_idle", 32'(bus.valid_o), 32'd0);
        if (redir)         check("redir_cycle_valid", 32'(bus.valid_o), 32'd0);
        if (prev_redir)    check("post_redir_valid", 32'(bus.valid_o), 32'd0);
        if (since_rst >= 2 && en_h2 && !prev_redir && !redir)
            check("stream_live", 32'(bus.valid_o), 32'd1);
        if (hold_v && !redir) begin
            check("hold_valid", 32'(bus.valid_o), 32'd1);
            check("hold_pc",    32'(bus.pc_o),    32'(hold_pc));
            check("hold_insn",  bus.insn_o,       hold_insn);
        end
        if (bus.valid_o === 1'b1) begin
            check("pc_order",  32'(bus.pc_o), 32'(exp_pc));
            check("insn_data", bus.insn_o,    mem[exp_pc]);
        end
`ifdef INSN_PREFETCH_PERF_EN
        check("perf_stall", bus.perf_stall_cnt_o,      32'(m_stall));
        check("perf_flush", 32'(bus.perf_flush_cnt_o), 32'(m_flush));
`endif
        xfer      = (bus.valid_o === 1'b1) && !stall;
        hold_v    = (bus.valid_o === 1'b1) && stall;
        hold_pc   = bus.pc_o;
        hold_insn = bus.insn_o;
        if ((bus.valid_o === 1'b1) && stall) m_stall++;
        if (redir) m_flush++;
        if (pulse_rst) begin
            #1 rst = 1'b0;
            #1 check_reset_outputs("midrst");
            #1 rst = 1'b1;
            exp_pc    = RST_PC;
            since_rst = 0;
            en_h1     = 0;
            hold_v    = 0;
            xfer      = 0;
            m_stall   = 0;
            m_flush   = 0;
        end
        @(posedge clk);
        if (redir)     exp_pc = raddr;
        else if (xfer) exp_pc = exp_pc + 8'd1;
        en_h2      = en_h1;
        en_h1      = en;
        prev_redir = redir;
        since_rst++;
    endtask

    task automatic run(input int n, input bit en, input bit stall);
        for (int i = 0; i < n; i++) step(en, 1'b0, '0, stall);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {16'($urandom), 16'h1000 + 16'(i)};
        bus.en_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_addr_i = '0; bus.stall_i = 1'b0;

        #2 check_reset_outputs("por");
        @(posedge clk); #2 check_reset_outputs("por_edge");
        rst = 1'b1;

        run(12, 1'b1, 1'b0);                          // power-on stream
        run(8, 1'b1, 1'b1);                           // stall fill
        run(10, 1'b1, 1'b0);                          // drain and resume
        step(1'b1, 1'b1, 8'h20, 1'b0);                // redirect mid-stream
        run(6, 1'b1, 1'b0);
        run(6, 1'b1, 1'b1);                           // fill, then redirect while stalled
        step(1'b1, 1'b1, 8'h40, 1'b1);
        run(6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hFE, 1'b0);                // address wrap
        run(6, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b0);                // redirect with fetch disabled
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            #1 check("en0_idle", 32'(bus.valid_o), 32'd0);
        end
        run(6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h10, 1'b0);                // back-to-back redirects
        step(1'b1, 1'b1, 8'h30, 1'b0);
        run(6, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1);                           // build occupancy, then reset
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        run(8, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            bit en, rd, st, pr;
            en = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            pr = !rd && ($urandom_range(0, 99) == 0);
            step(en, rd, 8'($urandom), st, pr);
        end
        run(4, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/insn_prefetcher.md
Name: insn_prefetcher

Overview:
- Parametrised successor of the single-entry instruction fetcher: sequential fetch from synchronous `memory_insn` (1-cycle read) into a DEPTH-entry prefetch queue.
- Adds redirect (branch/jump target load with flush of queue and in-flight read), a PC tag per instruction, and a fetch enable.
- Sits between instruction memory and decode; downstream handshake is valid_o/stall_i.

Parameters:
- LEN_INSN, from defs_insn.v: instruction width.
- MEM_INSN_ADDR, from defs_insn.v: instruction address width.
- DEPTH, 4: prefetch queue entries; legal minimum 2; power of two.
- RESET_ADDR, 0: first fetch address after reset (MEM_INSN_ADDR bits).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; asynchronous, active-low.
- en_i  in  1  fetch enable; 0 = issue no new reads (queue still drains).
- redirect_i  in  1  load redirect_addr_i as next fetch PC, flush.
- redirect_addr_i  in  MEM_INSN_ADDR  redirect target.
- stall_i  in  1  downstream not accepting.
- valid_o  out  1  queue head holds a valid instruction.
- insn_o  out  LEN_INSN  head instruction.
- pc_o  out  MEM_INSN_ADDR  address of insn_o.

Behaviour:
- Reset (rst=0, async): queue count=0, inflight=0, pc=RESET_ADDR, valid_o=0, insn_o/pc_o=0. Values persist until the first posedge with rst=1.
- Issue:
  - Memory address A = redirect_i ? redirect_addr_i : pc.
  - issue = en_i & (redirect_i | (count + inflight - pop < DEPTH)).
  - On issue, pc <= A+1 and inflight <= 1 at the edge.
- Wrap: pc increments modulo 2^MEM_INSN_ADDR; all-ones wraps to 0 with no stall.
- Return: Q is valid the cycle after issue. If inflight=1 and no redirect that cycle, {Q, issued addr} is pushed at that edge.
- Latency: issue in cycle N, valid_o in cycle N+2. With stall_i=0 and en_i=1, throughput is 1 insn/cycle for any DEPTH>=2.
- Output transfer: pop = valid_o & ~stall_i. Head advances at the edge.
  - insn_o and pc_o are held stable while valid_o & stall_i.
  - valid_o=0 when count=0. insn_o is don't-care then but must not be X after reset.
- Full: count=DEPTH, or credit exhausted → no issue. This never overflows, and no read result is dropped except on redirect.
- Redirect has priority over all other events in its cycle:
  - At the edge: count <= 0, pending read result discarded, new read issued from redirect_addr_i (if en_i).
  - valid_o is forced 0 during the redirect cycle, so no transfer occurs.
  - First target insn appears 2 cycles later.
- Redirect with en_i=0: pc <= redirect_addr_i, flush, no issue.
- Back-to-back redirects: only the last target survives.
- Simultaneous push+pop: count unchanged.
- Reset mid-operation: immediate async clear of all state and outputs, identical to power-on.

Optional Feature:
- Macro INSN_PREFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt_o[31:0] (cycles with valid_o & stall_i) and perf_flush_cnt_o[15:0] (redirect cycles, counted even when count=0 and inflight=0).
  - Both saturate at all-ones and reset to 0 on rst.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package (defs_insn.v): LEN_INSN, MEM_INSN_ADDR, and default DEPTH constant.
- Sub-module insn_fifo:
  - Parametrised LEN_INSN+MEM_INSN_ADDR wide, DEPTH deep, with flush, push, pop, count and head outputs.
  - Head is read combinationally.
  - Flush takes precedence over push.

Test Plan:
- Power-on: RESET_ADDR=0, memory[i]=0x1000+i, en_i=1, stall_i=0 from release.
  → valid_o rises in cycle 2; pc_o 0,1,2,… with insn_o 0x1000,0x1001,… every cycle, no gaps.
- Stall fill: DEPTH=4, stall_i=1 from cycle 5.
  → count reaches 4; A stops advancing; head stays stable.
  → Release: 4 queued entries delivered in order, then continuous stream, no loss or duplicate.
- Redirect: during stream, redirect_i=1 with redirect_addr_i=0x20 for one cycle.
  → valid_o=0 that cycle and the next; pc_o=0x20 two cycles later; no stale pc_o after the redirect.
- Redirect while full + stalled: count=4, stall_i=1, redirect to 0x40.
  → Queue empties; first valid entry has pc_o=0x40, insn mem[0x40].
- Wrap: MEM_INSN_ADDR=4, redirect to 0xE.
  → pc_o sequence 0xE, 0xF, 0x0, 0x1.
- Reset mid-stream: drop rst for <1 cycle between edges with count=3.
  → valid_o=0 immediately; after release, refetch from RESET_ADDR.
  → With INSN_PREFETCH_PERF_EN: counters read 0.
